// File: rtl/jtag_sram_pkg.sv
// Shared types and defaults for the JTAG-fed asynchronous SRAM writer.
// The readback states are only reached when READBACK_VERIFY_EN is defined.
package jtag_sram_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    RB_SETUP,
    RB_SAMPLE
  } sram_wr_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sram_req_t;

  // A programmed phase length of zero still takes one cycle.
  function automatic int unsigned cyc_len(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular request buffer with wrap-bit pointers and registered full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic             full_q, empty_q, full_d, empty_d;
  logic             do_push, do_pop;

  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_q | do_pop);

  always_comb begin
    wr_d    = wr_q + PTR_W'(do_push);
    rd_d    = rd_q + PTR_W'(do_pop);
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[PTR_W-1] != rd_d[PTR_W-1]) && (wr_d[IDX_W-1:0] == rd_d[IDX_W-1:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[IDX_W-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[IDX_W-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/jtag_sram_writer.sv
// Buffers JTAG write requests and replays each as a timed async-SRAM write cycle.
// Define READBACK_VERIFY_EN to add a read-back compare after every write.
module jtag_sram_writer
  import jtag_sram_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              tck,
  input  logic              aclr,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy,
  output logic              fifo_full,
  output logic [15:0]       wr_count,
  output logic [7:0]        drop_count
`ifdef READBACK_VERIFY_EN
  ,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              verify_err,
  output logic [ADDR_W-1:0] err_addr
`endif
);

  localparam int unsigned S_LEN  = cyc_len(SETUP_CYC);
  localparam int unsigned P_LEN  = cyc_len(PULSE_CYC);
  localparam int unsigned H_LEN  = cyc_len(HOLD_CYC);
  localparam int unsigned RB_LEN = S_LEN + P_LEN;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned REQ_W  = ADDR_W + DATA_W;
`ifdef READBACK_VERIFY_EN
  localparam sram_wr_state_e AFTER_HOLD = RB_SETUP;
  localparam sram_wr_state_e LAST_ST    = RB_SAMPLE;
`else
  localparam sram_wr_state_e AFTER_HOLD = IDLE;
  localparam sram_wr_state_e LAST_ST    = HOLD;
`endif

  sram_wr_state_e    state_q, state_d, nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d, dur;
  logic              req_we_q, push, pop, wr_done;
  logic              fifo_full_w, fifo_empty;
  logic [REQ_W-1:0]  fifo_rdata;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic              ce_n_q, we_n_q, dq_oe_q;
  logic [15:0]       wr_count_q;
  logic [7:0]        drop_count_q;

  assign push = req_we & ~req_we_q;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (tck),
    .rst_i   (aclr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({req_addr, req_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty)
  );

  // Phase sequencing: each active state runs for its own cycle budget.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    dur     = CNT_W'(1);
    nxt     = IDLE;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin dur = CNT_W'(S_LEN); nxt = PULSE;      end
      PULSE: begin dur = CNT_W'(P_LEN); nxt = HOLD;       end
      HOLD:  begin dur = CNT_W'(H_LEN); nxt = AFTER_HOLD; end
`ifdef READBACK_VERIFY_EN
      RB_SETUP:  begin dur = CNT_W'(RB_LEN); nxt = RB_SAMPLE; end
      RB_SAMPLE: begin dur = CNT_W'(1);      nxt = IDLE;      end
`endif
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      if (cnt_q == dur - CNT_W'(1)) begin
        state_d = nxt;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    wr_done = (state_q == LAST_ST) && (cnt_q == dur - CNT_W'(1));
  end

  // Strobes are registered from the current phase, trailing it by one cycle.
  always_ff @(posedge tck) begin
    if (aclr) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_we_q     <= 1'b0;
      a_q          <= '0;
      d_q          <= '0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      wr_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_we_q <= req_we;
      if (pop) {a_q, d_q} <= fifo_rdata;
      ce_n_q     <= (state_q == IDLE);
      we_n_q     <= (state_q != PULSE);
      dq_oe_q    <= (state_q == SETUP) || (state_q == PULSE) || (state_q == HOLD);
      wr_count_q <= wr_count_q + 16'(wr_done);
      if (push && fifo_full_w && !pop && (drop_count_q != 8'hFF))
        drop_count_q <= drop_count_q + 8'd1;
    end
  end

`ifdef READBACK_VERIFY_EN
  logic              oe_n_q, verify_err_q;
  logic [ADDR_W-1:0] err_addr_q;

  always_ff @(posedge tck) begin
    if (aclr) begin
      oe_n_q       <= 1'b1;
      verify_err_q <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      oe_n_q <= !((state_q == RB_SETUP) || (state_q == RB_SAMPLE));
      if ((state_q == RB_SAMPLE) && (sram_dq_i != d_q)) begin
        verify_err_q <= 1'b1;
        err_addr_q   <= a_q;
      end
    end
  end

  assign sram_oe_n  = oe_n_q;
  assign verify_err = verify_err_q;
  assign err_addr   = err_addr_q;
`else
  assign sram_oe_n  = 1'b1;
`endif

  assign sram_a     = a_q;
  assign sram_dq_o  = d_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_we_n  = we_n_q;
  assign busy       = ~fifo_empty | (state_q != IDLE);
  assign fifo_full  = fifo_full_w;
  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_jtag_sram_writer.sv
// Bench for jtag_sram_writer: two instances (default timing and 3/4/2 timing)
// checked every cycle against a queue-and-time-window model of the request flow.
module tb_jtag_sram_writer;

  localparam int D = 4;
`ifdef READBACK_VERIFY_EN
  localparam int RB_ON = 1;
`else
  localparam int RB_ON = 0;
`endif

  logic        tck = 1'b0;
  logic        aclr, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_data;

  logic [1:0][15:0] o_a, o_wr;
  logic [1:0][7:0]  o_dq, o_drop;
  logic [1:0]       o_oe, o_ce, o_we, o_rd, o_busy, o_full;

  always #5 tck = ~tck;

`ifdef READBACK_VERIFY_EN
  logic [1:0][7:0]  dq_in;
  logic [1:0]       o_verr;
  logic [1:0][15:0] o_eaddr;
  // SRAM model returns the written byte, with bit 0 flipped at address 0x0010.
  assign dq_in[0] = o_dq[0] ^ {7'b0, o_a[0] == 16'h0010};
  assign dq_in[1] = o_dq[1] ^ {7'b0, o_a[1] == 16'h0010};
`endif

  jtag_sram_writer #(.FIFO_DEPTH(D), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_dut0 (
    .tck(tck), .aclr(aclr), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .sram_a(o_a[0]), .sram_dq_o(o_dq[0]), .sram_dq_oe(o_oe[0]), .sram_ce_n(o_ce[0]),
    .sram_we_n(o_we[0]), .sram_oe_n(o_rd[0]), .busy(o_busy[0]), .fifo_full(o_full[0]),
    .wr_count(o_wr[0]), .drop_count(o_drop[0])
`ifdef READBACK_VERIFY_EN
    , .sram_dq_i(dq_in[0]), .verify_err(o_verr[0]), .err_addr(o_eaddr[0])
`endif
  );

  jtag_sram_writer #(.FIFO_DEPTH(D), .SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) u_dut1 (
    .tck(tck), .aclr(aclr), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .sram_a(o_a[1]), .sram_dq_o(o_dq[1]), .sram_dq_oe(o_oe[1]), .sram_ce_n(o_ce[1]),
    .sram_we_n(o_we[1]), .sram_oe_n(o_rd[1]), .busy(o_busy[1]), .fifo_full(o_full[1]),
    .wr_count(o_wr[1]), .drop_count(o_drop[1])
`ifdef READBACK_VERIFY_EN
    , .sram_dq_i(dq_in[1]), .verify_err(o_verr[1]), .err_addr(o_eaddr[1])
`endif
  );

  // Reference model: request queues plus the edge of the last pop per instance.
  int          checks = 0, errors = 0;
  int          t = 0;
  int          sv[2], pv[2], hv[2], len[2], lp[2], np[2];
  bit          hp[2], prev;
  logic [23:0] q0[$], q1[$];
  logic [23:0] le[2];
  logic [15:0] m_wr[2], m_eaddr[2];
  logic [7:0]  m_drop[2];
  bit          m_verr[2];

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0d observed %0h expected %0h", tag, k, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    t++;
    if (aclr) begin
      q0.delete();
      q1.delete();
      prev = 1'b0;
      for (int k = 0; k < 2; k++) begin
        hp[k] = 1'b0; np[k] = 0; le[k] = '0; m_wr[k] = '0; m_drop[k] = '0;
        m_verr[k] = 1'b0; m_eaddr[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int sz;
        logic [23:0] e;
        sz = qsize(k);
        if (hp[k] && t == lp[k] + len[k]) begin
          m_wr[k] = m_wr[k] + 16'd1;
          if (RB_ON != 0 && le[k][23:8] == 16'h0010) begin
            m_verr[k] = 1'b1;
            m_eaddr[k] = le[k][23:8];
          end
        end
        if (t >= np[k] && sz > 0) begin
          if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
          le[k] = e; lp[k] = t; hp[k] = 1'b1; np[k] = t + len[k] + 1; sz--;
        end
        if (req_we && !prev) begin
          if (sz < D) begin
            if (k == 0) q0.push_back({req_addr, req_data}); else q1.push_back({req_addr, req_data});
          end else if (m_drop[k] != 8'hFF) begin
            m_drop[k] = m_drop[k] + 8'd1;
          end
        end
      end
      prev = req_we;
    end
  endtask

  task automatic sample();
    for (int k = 0; k < 2; k++) begin
      int rel;
      bit ce_lo, we_lo, drv, rd_lo;
      rel   = t - lp[k];
      ce_lo = hp[k] && rel >= 1 && rel <= len[k];
      we_lo = hp[k] && rel >= sv[k] + 1 && rel <= sv[k] + pv[k];
      drv   = hp[k] && rel >= 1 && rel <= sv[k] + pv[k] + hv[k];
      rd_lo = hp[k] && rel >= sv[k] + pv[k] + hv[k] + 1 && rel <= len[k];
      chk("ce_n", k, 32'(o_ce[k]), 32'(!ce_lo));
      chk("we_n", k, 32'(o_we[k]), 32'(!we_lo));
      chk("dq_oe", k, 32'(o_oe[k]), 32'(drv));
      chk("oe_n", k, 32'(o_rd[k]), 32'(!rd_lo));
      chk("sram_a", k, 32'(o_a[k]), 32'(le[k][23:8]));
      chk("sram_dq", k, 32'(o_dq[k]), 32'(le[k][7:0]));
      chk("busy", k, 32'(o_busy[k]), 32'((qsize(k) > 0) || (hp[k] && t < lp[k] + len[k])));
      chk("fifo_full", k, 32'(o_full[k]), 32'(qsize(k) == D));
      chk("wr_count", k, 32'(o_wr[k]), 32'(m_wr[k]));
      chk("drop_count", k, 32'(o_drop[k]), 32'(m_drop[k]));
`ifdef READBACK_VERIFY_EN
      chk("verify_err", k, 32'(o_verr[k]), 32'(m_verr[k]));
      chk("err_addr", k, 32'(o_eaddr[k]), 32'(m_eaddr[k]));
`endif
    end
  endtask

  task automatic cyc();
    @(posedge tck);
    model_edge();
    @(negedge tck);
    sample();
  endtask

  initial begin
    bit seen;
    sv = '{1, 3}; pv = '{2, 4}; hv = '{1, 2};
    for (int k = 0; k < 2; k++) len[k] = sv[k] + pv[k] + hv[k] + RB_ON * (sv[k] + pv[k] + 1);
    aclr = 1'b1; req_we = 1'b0; req_addr = '0; req_data = '0;
    cyc(); cyc();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ce_n", k, 32'(o_ce[k]), 32'd1);
      chk("rst_we_n", k, 32'(o_we[k]), 32'd1);
      chk("rst_busy", k, 32'(o_busy[k]), 32'd0);
      chk("rst_a", k, 32'(o_a[k]), 32'd0);
    end
    aclr = 1'b0;
    cyc();

    // Single request.
    req_we = 1'b1; req_addr = 16'h1234; req_data = 8'hA5;
    cyc();
    req_we = 1'b0;
    repeat (12 + 9 * RB_ON) cyc();
    for (int k = 0; k < 2; k++) begin
      chk("single_wr", k, 32'(o_wr[k]), 32'd1);
      chk("single_a", k, 32'(o_a[k]), 32'h1234);
      chk("single_dq", k, 32'(o_dq[k]), 32'hA5);
      chk("single_idle", k, 32'(o_busy[k]), 32'd0);
    end

    // Held level gives exactly one write.
    req_we = 1'b1; req_addr = 16'h00FF; req_data = 8'h3C;
    repeat (50) cyc();
    req_we = 1'b0;
    repeat (5) cyc();
    for (int k = 0; k < 2; k++) begin
      chk("held_wr", k, 32'(o_wr[k]), 32'd2);
      chk("held_idle", k, 32'(o_busy[k]), 32'd0);
    end

    // Burst of eight edges, two cycles apart, overruns the buffer.
    for (int i = 0; i < 8; i++) begin
      req_we = 1'b1; req_addr = 16'($urandom); req_data = 8'($urandom);
      cyc();
      req_we = 1'b0;
      cyc();
    end
    repeat (100) cyc();
`ifndef READBACK_VERIFY_EN
    chk("burst_drop", 0, 32'(o_drop[0]), 32'd1);
    chk("burst_drop", 1, 32'(o_drop[1]), 32'd2);
    chk("burst_wr", 0, 32'(o_wr[0]), 32'd9);
    chk("burst_wr", 1, 32'(o_wr[1]), 32'd8);
`endif

    // Reset while the write strobe is low.
    req_we = 1'b1; req_addr = 16'h0ABC; req_data = 8'h11;
    cyc();
    req_we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (o_we[0] == 1'b0) seen = 1'b1;
    end
    chk("we_low_seen", 0, 32'(seen), 32'd1);
    aclr = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("abort_we_n", k, 32'(o_we[k]), 32'd1);
      chk("abort_ce_n", k, 32'(o_ce[k]), 32'd1);
      chk("abort_wr", k, 32'(o_wr[k]), 32'd0);
      chk("abort_drop", k, 32'(o_drop[k]), 32'd0);
      chk("abort_full", k, 32'(o_full[k]), 32'd0);
    end
    aclr = 1'b0;
    repeat (20) cyc();
    for (int k = 0; k < 2; k++) chk("abort_no_write", k, 32'(o_wr[k]), 32'd0);

    // Randomised traffic, including the corrupting address.
    for (int i = 0; i < 400; i++) begin
      req_we   = ($urandom_range(0, 3) == 0);
      req_addr = ($urandom_range(0, 4) == 0) ? 16'h0010 : 16'($urandom);
      req_data = 8'($urandom);
      cyc();
    end
    req_we = 1'b0;
    repeat (150) cyc();
    for (int k = 0; k < 2; k++) chk("final_idle", k, 32'(o_busy[k]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_sram_writer.md
Name: jtag_sram_writer

Overview:
Downstream consumer of the JTAG virtual-DR interface. Accepts address/data write requests, buffers them in a small FIFO and plays each one onto an asynchronous external SRAM bus with a timed write cycle (CE/WE strobes, address setup/hold). Provides status counters for the JTAG/debug side.

Parameters:
ADDR_W, 16, SRAM address width
DATA_W, 8, SRAM data width
FIFO_DEPTH, 4, request buffer entries (power of 2, >=2)
SETUP_CYC, 1, tck cycles address/data stable before WE low
PULSE_CYC, 2, tck cycles WE held low
HOLD_CYC, 1, tck cycles address/data held after WE high

Ports:
tck  in  1  clock
aclr  in  1  reset, synchronous, active-high
req_we  in  1  write-request level from JTAG interface; a write is issued on each 0->1 transition
req_addr  in  ADDR_W  write address, sampled on the req_we rising edge
req_data  in  DATA_W  write data, sampled on the req_we rising edge
sram_a  out  ADDR_W  SRAM address bus
sram_dq_o  out  DATA_W  SRAM data out
sram_dq_oe  out  1  data-bus drive enable
sram_ce_n  out  1  chip enable, active-low
sram_we_n  out  1  write enable, active-low
sram_oe_n  out  1  output enable, active-low
busy  out  1  FIFO not empty or FSM not IDLE
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
wr_count  out  16  completed SRAM writes
drop_count  out  8  requests lost to overflow

Behaviour:
- Reset (aclr=1 at tck edge): FSM=IDLE, FIFO empty, sram_a=0, sram_dq_o=0, sram_dq_oe=0, sram_ce_n=1, sram_we_n=1, sram_oe_n=1, busy=0, fifo_full=0, wr_count=0, drop_count=0, edge-detect register=0. Reset mid-cycle aborts the write: strobes deassert on the next edge and queued requests are discarded.
- Edge detect: req_we is registered once. push = req_we & ~req_we_q. A held-high level produces exactly one push. req_addr/req_data are captured in the same cycle.
- Push while full: entry dropped, drop_count increments, saturating at 255. Push and pop in the same cycle while full: pop frees a slot, so the push is accepted.
- FIFO: circular, ptr width log2(FIFO_DEPTH)+1, with wrap-bit full/empty detection. Occupancy never exceeds FIFO_DEPTH.
- FSM states:
  - IDLE: when FIFO is non-empty, pop the head into a_q/d_q and go to SETUP. If the FIFO is empty, stay in IDLE.
  - SETUP: ce_n=0, dq_oe=1, we_n=1 for SETUP_CYC cycles, then go to PULSE.
  - PULSE: we_n=0 for PULSE_CYC cycles, then go to HOLD.
  - HOLD: we_n=1, ce_n=0, dq_oe=1 for HOLD_CYC cycles. On exit, wr_count increments (wraps at 2^16), and the FSM goes back to IDLE, releasing ce_n=1 and dq_oe=0.
- sram_a and sram_dq_o equal a_q/d_q from SETUP through HOLD and are held stable at their last value in IDLE.
- sram_oe_n is always 1 unless READBACK_VERIFY_EN is defined.
- Single-cycle counter per state; parameter value 0 is treated as 1.
- Latency: push at edge N; FSM leaves IDLE at N+1 if it was idle; we_n falls at N+2+SETUP_CYC.
- Every strobe is a registered output, so no glitches.

Optional Feature:
READBACK_VERIFY_EN
- Defined:
  - Adds states RB_SETUP and RB_SAMPLE after HOLD. RB_SETUP drives oe_n=0, dq_oe=0 and ce_n=0 for SETUP_CYC+PULSE_CYC cycles. RB_SAMPLE compares input port sram_dq_i[DATA_W] against d_q.
  - Mismatch: verify_err (sticky output, cleared only by aclr) is set and err_addr[ADDR_W] captures the address.
  - wr_count then increments on RB_SAMPLE exit.
- Undefined: the ports sram_dq_i, verify_err and err_addr are absent, and those states are not compiled.

Decomposition:
- Package jtag_sram_pkg:
  - state enum sram_wr_state_e (IDLE, SETUP, PULSE, HOLD, RB_SETUP, RB_SAMPLE)
  - typedef sram_req_t struct {addr, data}
  - default ADDR_W/DATA_W localparams
- Sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty, synchronous active-high reset). Edge detect, FSM and counters live in the top module.

Test Plan:
- Reset then single request: req_we 0->1 with addr=0x1234, data=0xA5 -> exactly one we_n low pulse of 2 cycles; sram_a=0x1234 and sram_dq_o=0xA5 stable from SETUP through HOLD; wr_count=1.
- Held level: req_we high for 50 cycles -> one write only; wr_count=1; busy returns to 0.
- Burst overflow: 6 rising edges spaced 2 cycles apart with FIFO_DEPTH=4 -> drop_count=1, wr_count=5, writes issued in order, fifo_full asserted while 4 entries are held.
- Reset during PULSE: assert aclr while we_n=0 -> next edge we_n=1, ce_n=1, FIFO empty, counters 0; no further writes after release.
- Timing parameters: SETUP_CYC=3, PULSE_CYC=4, HOLD_CYC=2 -> measured we_n low for 4 cycles, 3 cycles of address before the falling edge, 2 cycles after the rising edge.
- READBACK_VERIFY_EN: SRAM model corrupts bit 0 at addr 0x0010 -> verify_err=1, err_addr=0x0010; clean addresses leave verify_err at 0.
